// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_CSUM   = 3'd5,
        ST_DONE   = 3'd6
    } loader_state_t;

    // Length header bytes (LEN_LO, LEN_HI); they are not part of the checksum.
    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_word_assembler.sv
// Little-endian byte-to-word assembler with a running XOR of every byte taken in.
module imem_word_assembler
    import imem_loader_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          byte_en,
    input  logic [7:0]                    byte_in,
    output logic [8*BYTES_PER_WORD-1:0]   word,
    output logic [7:0]                    csum,
    output logic                          word_full
);

    logic [8*BYTES_PER_WORD-1:0] word_q, word_d;
    logic [7:0]                  csum_q, csum_d;
    logic [1:0]                  byte_cnt_q, byte_cnt_d;

    // Shift bytes in from the top so byte 0 ends up in bits [7:0] after the 4th byte.
    always_comb begin
        word_d     = word_q;
        csum_d     = csum_q;
        byte_cnt_d = byte_cnt_q;
        if (clear) begin
            word_d     = '0;
            csum_d     = '0;
            byte_cnt_d = '0;
        end else if (byte_en) begin
            word_d     = {byte_in, word_q[8*BYTES_PER_WORD-1:8]};
            csum_d     = csum_q ^ byte_in;
            byte_cnt_d = byte_cnt_q + 2'd1;
        end
    end

    // Assembler registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q     <= '0;
            csum_q     <= '0;
            byte_cnt_q <= '0;
        end else begin
            word_q     <= word_d;
            csum_q     <= csum_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    // Flags the edge on which the last byte of a word is being taken.
    always_comb begin
        word      = word_q;
        csum      = csum_q;
        word_full = byte_en && (byte_cnt_q == 2'(BYTES_PER_WORD - 1));
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader: parses length/data/checksum stream and writes the instruction memory.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    loader_state_t    state_q, state_d;
    logic [7:0]       len_lo_q, len_lo_d;
    logic [ADDR_W:0]  n_q, n_d;
    logic [ADDR_W:0]  words_q, words_d;
    logic             error_q, error_d;

    logic             busy_int;
    logic             start_ok;
    logic             byte_acc;
    logic             asm_en;
    logic             asm_full;
    logic [31:0]      asm_word;
    logic [7:0]       asm_csum;
    logic [15:0]      n_full;
    logic             n_too_big;
    logic [ADDR_W:0]  words_inc;

    assign busy_int  = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign start_ok  = start && !busy_int;
    assign byte_acc  = in_valid && in_ready;
    assign asm_en    = (state_q == ST_DATA) && in_valid;
    assign n_full    = {in_data, len_lo_q};
    assign n_too_big = n_full > 16'(DEPTH);
    assign words_inc = words_q + 1'b1;

    imem_word_assembler u_asm (
        .clk       (clk),
        .rst       (reset),
        .clear     (start_ok),
        .byte_en   (asm_en),
        .byte_in   (in_data),
        .word      (asm_word),
        .csum      (asm_csum),
        .word_full (asm_full)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: if (start_ok) state_d = ST_LEN_LO;
            ST_LEN_LO:        if (byte_acc) state_d = ST_LEN_HI;
            ST_LEN_HI: begin
                if (byte_acc) begin
                    if (n_too_big)          state_d = ST_DONE;
                    else if (n_full == '0)  state_d = ST_CSUM;
                    else                    state_d = ST_DATA;
                end
            end
            ST_DATA:  if (asm_full) state_d = ST_WRITE;
            ST_WRITE: state_d = (words_inc == n_q) ? ST_CSUM : ST_DATA;
            ST_CSUM:  if (byte_acc) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Length capture, word counter and sticky error.
    always_comb begin
        len_lo_d = len_lo_q;
        n_d      = n_q;
        words_d  = words_q;
        error_d  = error_q;
        if (start_ok) begin
            len_lo_d = '0;
            n_d      = '0;
            words_d  = '0;
            error_d  = 1'b0;
        end else begin
            case (state_q)
                ST_LEN_LO: if (byte_acc) len_lo_d = in_data;
                ST_LEN_HI: begin
                    if (byte_acc) begin
                        // Only the low bits are kept; anything wider is rejected here.
                        n_d = n_full[ADDR_W:0];
                        if (n_too_big) error_d = 1'b1;
                    end
                end
                ST_WRITE: words_d = words_inc;
                ST_CSUM:  if (byte_acc && (in_data != asm_csum)) error_d = 1'b1;
                default: ;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_lo_q <= '0;
            n_q      <= '0;
            words_q  <= '0;
            error_q  <= 1'b0;
        end else begin
            len_lo_q <= len_lo_d;
            n_q      <= n_d;
            words_q  <= words_d;
            error_q  <= error_d;
        end
    end

    // Moore outputs decoded from state and registers only.
    always_comb begin
        in_ready     = (state_q == ST_LEN_LO) || (state_q == ST_LEN_HI) ||
                       (state_q == ST_DATA)   || (state_q == ST_CSUM);
        mem_we       = (state_q == ST_WRITE);
        mem_addr     = words_q[ADDR_W-1:0];
        mem_wdata    = asm_word;
        busy         = busy_int;
        done         = (state_q == ST_DONE);
        error        = error_q;
        // The CPU is released only after a clean load.
        cpu_hold     = !((state_q == ST_DONE) && !error_q);
        words_loaded = words_q;
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: full loads, bad checksum, oversize length, empty load, gaps, reset.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [8:0]  words_loaded;

    int checks   = 0;
    int failures = 0;
    bit gap_mode = 1'b0;

    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];
    int          ready_viol = 0;
    logic [31:0] prog [9];

    imem_loader #(.DEPTH(256), .ADDR_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    // Mid-cycle write logger.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
            if (in_ready) ready_viol++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] csum_of(input int n);
        logic [7:0] x = 8'h00;
        for (int i = 0; i < n; i++)
            x = x ^ prog[i][7:0] ^ prog[i][15:8] ^ prog[i][23:16] ^ prog[i][31:24];
        return x;
    endfunction

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [7:0] b);
        bit got = 1'b0;
        bit r;
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 64 && !got; t++) begin
            r = in_ready;
            @(negedge clk);
            if (r) got = 1'b1;
        end
        in_valid = 1'b0;
        chk("byte_accept", 32'(got), 32'd1);
    endtask

    task automatic gap();
        int g;
        g = gap_mode ? int'($urandom_range(0, 2)) : 0;
        repeat (g) begin
            in_valid = 1'b0;
            start    = ($urandom_range(0, 2) == 0);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int idx);
        for (int k = 0; k < 4; k++) begin
            gap();
            send_byte(w[8*k +: 8]);
        end
        chk("we_latency", 32'(mem_we), 32'd1);
        chk("we_addr", 32'(mem_addr), 32'(idx));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("ready_after_start", 32'(in_ready), 32'd1);
    endtask

    task automatic run_load(input int n, input logic [7:0] cs);
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        gap(); send_byte(8'(n));
        gap(); send_byte(8'h00);
        for (int i = 0; i < n; i++) send_word(prog[i], i);
        gap(); send_byte(cs);
    endtask

    task automatic check_writes(input int n, input string tag);
        chk({tag, "_nwrites"}, 32'(wr_addr.size()), 32'(n));
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            chk({tag, "_addr"}, 32'(wr_addr[i]), 32'(i));
            chk({tag, "_data"}, wr_data[i], prog[i]);
        end
    endtask

    task automatic check_status(input string tag, input logic d, input logic e,
                                input logic h, input int wl);
        chk({tag, "_done"}, 32'(done), 32'(d));
        chk({tag, "_error"}, 32'(error), 32'(e));
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(h));
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_words"}, 32'(words_loaded), 32'(wl));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
        chk({tag, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    initial begin
        prog[0] = 32'hE3A00003; prog[1] = 32'hE3A01001; prog[2] = 32'hE0800001;
        prog[3] = 32'hE2511001; prog[4] = 32'h1AFFFFFC; prog[5] = 32'hE59F2004;
        prog[6] = 32'hE5820000; prog[7] = 32'hE3A03000; prog[8] = 32'hE5923000;

        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h55;
        @(negedge clk);
        chk("idle_not_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;

        // Full bring-up program, correct checksum.
        run_load(9, csum_of(9));
        check_status("load9", 1'b1, 1'b0, 1'b0, 9);
        check_writes(9, "load9");

        // One word with a wrong checksum (correct value is 0x40).
        run_load(1, 8'h41);
        check_status("badcs", 1'b1, 1'b1, 1'b1, 1);
        check_writes(1, "badcs");

        // Oversize length N=300.
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        send_byte(8'h2C);
        send_byte(8'h01);
        check_status("big", 1'b1, 1'b1, 1'b1, 0);
        chk("big_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        chk("big_nwrites", 32'(wr_addr.size()), 32'd0);
        chk("big_still_done", 32'(done), 32'd1);

        // Empty load.
        run_load(0, 8'h00);
        check_status("empty", 1'b1, 1'b0, 1'b0, 0);
        chk("empty_nwrites", 32'(wr_addr.size()), 32'd0);

        // Full load with random valid gaps and stray start pulses.
        gap_mode   = 1'b1;
        ready_viol = 0;
        run_load(9, csum_of(9));
        gap_mode = 1'b0;
        check_status("gaps", 1'b1, 1'b0, 1'b0, 9);
        check_writes(9, "gaps");
        chk("gaps_ready_in_write", 32'(ready_viol), 32'd0);

        // Reset in the middle of a load after two words.
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        send_byte(8'h09);
        send_byte(8'h00);
        send_word(prog[0], 0);
        send_word(prog[1], 1);
        @(negedge clk);
        chk("midrst_nwrites", 32'(wr_addr.size()), 32'd2);
        reset = 1'b1;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_load(1, 8'h40);
        check_status("after_rst", 1'b1, 1'b0, 1'b0, 1);
        check_writes(1, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
